// File: rtl/uart_transmitter_pkg.sv
// Shared UART transmit definitions: FSM states, frame geometry, IO map constants.
// Purely declarative; no logic, no latency, no backpressure.
package uart_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // Memory-mapped IO addresses of the UART block this transmitter sits behind.
  localparam logic [31:0] IO_STATUS_ADDR  = 32'h8000_0000;
  localparam logic [31:0] IO_RX_DATA_ADDR = 32'h8000_0004;
  localparam logic [31:0] IO_TX_DATA_ADDR = 32'h8000_0008;

  function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with combinational head (dout); push/pop take effect on the edge.
// Push ignored when full, pop ignored when empty; full/empty derive from a registered count.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(Depth));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Depth is a power of two, so the pointers wrap for free.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter; SOut falls one edge after a byte lands in an idle, empty FIFO.
// DataInReady drops while the FIFO is full or in reset; frames run back to back while bytes wait.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200,
  parameter int FifoDepth = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut,
  output logic       Busy
);

  localparam int ClocksPerBit = clocks_per_bit(ClockFreq, BaudRate);
  localparam int BaudW        = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClocksPerBit - 1);
  localparam logic [2:0]       LastBit  = 3'(UART_DATA_BITS - 1);

  tx_state_t        r_state;
  logic [BaudW-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_sout;

  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_fifo_dout;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_done;

  assign DataInReady = !Reset && !w_fifo_full;
  assign Busy        = !Reset && ((r_state != ST_IDLE) || !w_fifo_empty);
  assign SOut        = r_sout;

  assign w_push     = DataInValid && DataInReady;
  assign w_bit_done = (r_baud_cnt == BaudLast);
  // The only pop points: leaving IDLE, or the last cycle of a stop bit.
  assign w_pop = !Reset && !w_fifo_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));

  uart_tx_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (w_push),
    .din   (DataIn),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_sout     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sout     <= 1'b1;
          r_baud_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_sout  <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_sout     <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == LastBit) begin
              r_sout  <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              // Bit 0 of the shifter is always the bit currently on the line.
              r_shift   <= r_shift >> 1;
              r_sout    <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_dout;
              r_sout  <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_sout  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
